// File: rtl/mapache64.sv
// Shared types for the mapache64 console blocks.
// Holds the byte type and the controller-emulator state encoding.
package mapache64;

  typedef logic [7:0] data_t;

  localparam int unsigned PAD_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } controller_emu_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous pin, plus single-cycle rise/fall
// pulses derived from the synchronized level against its previous value.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: non-blocking assignments make the three flops sample together;
  // blocking ones here would collapse the chain into a single stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/controller_emulator.sv
// Emulates NUM_CONTROLLERS NES-style pads on a host-driven latch/clock port:
// parallel load while latch is high, then MSB-first active-low serial shift-out.
module controller_emulator
  import mapache64::*;
#(
  parameter int unsigned NUM_CONTROLLERS = 2,
  parameter logic        FILL_BIT        = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                latch_i,
  input  logic                                ctrl_clk_i,
  input  logic [NUM_CONTROLLERS*PAD_BITS-1:0] buttons_LIST_i,
  output logic [NUM_CONTROLLERS-1:0]          serial_LIST_no,
  output logic                                busy_o,
  output logic                                read_done_o,
  output logic                                timeout_o
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST_BIT = 4'd7;
  localparam logic [3:0] BIT_SAT  = 4'd8;

  logic latch_sync, latch_rise, latch_fall;
  logic clk_sync, clk_rise, clk_fall;

  sync_edge_detect u_latch_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (latch_i),
    .sync_o  (latch_sync),
    .rise_o  (latch_rise),
    .fall_o  (latch_fall)
  );

  sync_edge_detect u_ctrl_clk_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (ctrl_clk_i),
    .sync_o  (clk_sync),
    .rise_o  (clk_rise),
    .fall_o  (clk_fall)
  );

  // The latch level already covers its rising edge, and only the clock rise shifts.
  logic unused_edges;
  assign unused_edges = ^{latch_rise, clk_sync, clk_fall};

  controller_emu_state_t state_q, state_d;
  logic [3:0]            bit_cnt_q;
  logic [TMO_W-1:0]      tmo_cnt_q;
  logic                  read_done_q, timeout_q;

  logic load_en, shift_en;
  logic bit_clr, bit_inc;
  logic tmo_clr, tmo_inc;
  logic read_done_d, timeout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    load_en     = 1'b0;
    shift_en    = 1'b0;
    bit_clr     = 1'b0;
    bit_inc     = 1'b0;
    tmo_clr     = 1'b0;
    tmo_inc     = 1'b0;
    read_done_d = 1'b0;
    timeout_d   = 1'b0;

    if (latch_sync) begin
      // Latch dominates everything, including a coincident clock rise.
      state_d = LOAD;
      load_en = 1'b1;
      bit_clr = 1'b1;
      tmo_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          shift_en = clk_rise;
        end
        LOAD: begin
          tmo_clr = 1'b1;
          if (latch_fall) state_d = SHIFT;
        end
        SHIFT: begin
          if (clk_rise) begin
            shift_en = 1'b1;
            bit_inc  = 1'b1;
            tmo_clr  = 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              read_done_d = 1'b1;
              state_d     = DONE;
            end
          end else if (tmo_cnt_q == TMO_LAST) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end else begin
            tmo_inc = 1'b1;
          end
        end
        DONE: begin
          if (clk_rise) begin
            shift_en = 1'b1;
            bit_inc  = (bit_cnt_q != BIT_SAT);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      read_done_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      if (bit_clr)      bit_cnt_q <= '0;
      else if (bit_inc) bit_cnt_q <= bit_cnt_q + 4'd1;

      if (tmo_clr)      tmo_cnt_q <= '0;
      else if (tmo_inc) tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);

      read_done_q <= read_done_d;
      timeout_q   <= timeout_d;
    end
  end

  for (genvar k = 0; k < NUM_CONTROLLERS; k++) begin : g_pad
    data_t shreg;

    // NOTE: the shift register is reset, unlike a storage array, because its
    // MSB drives the pin and must idle as a released (high) line.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)           shreg <= '0;
      else if (load_en)  shreg <= buttons_LIST_i[PAD_BITS*k +: PAD_BITS];
      else if (shift_en) shreg <= {shreg[6:0], FILL_BIT};
    end

    assign serial_LIST_no[k] = ~shreg[7];
  end

  assign busy_o      = (state_q != IDLE);
  assign read_done_o = read_done_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_controller_emulator.sv
// Directed bench for controller_emulator: host-side latch/clock sequences with
// hand-computed expected button words and pulse counts.
module tb_controller_emulator;

  localparam int N = 2;
  localparam int T = 4096;

  logic         clk = 1'b0;
  logic         rst;
  logic         latch;
  logic         cclk;
  logic [15:0]  buttons;
  logic [1:0]   serial;
  logic         busy;
  logic         rdone;
  logic         tmo;

  always #5 clk = ~clk;

  controller_emulator #(
    .NUM_CONTROLLERS (N),
    .FILL_BIT        (1'b1),
    .TIMEOUT_CYCLES  (T)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .latch_i        (latch),
    .ctrl_clk_i     (cclk),
    .buttons_LIST_i (buttons),
    .serial_LIST_no (serial),
    .busy_o         (busy),
    .read_done_o    (rdone),
    .timeout_o      (tmo)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Pulse monitor samples on the falling edge; the stimulus acts 1 unit later.
  int         done_seen = 0;
  int         tmo_seen  = 0;
  logic [1:0] serial_at_done = 2'b11;

  always @(negedge clk) begin
    if (rdone) begin
      done_seen++;
      serial_at_done = serial;
    end
    if (tmo) tmo_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic latch_pulse();
    latch = 1'b1;
    cyc(4);
    latch = 1'b0;
    cyc(4);
  endtask

  task automatic clk_pulse();
    cclk = 1'b1;
    cyc(4);
    cclk = 1'b0;
    cyc(4);
  endtask

  // Host read: sample the inverted pin, then clock; 8 clocks per read.
  task automatic read_bits(output logic [7:0] r0, output logic [7:0] r1);
    for (int i = 7; i >= 0; i--) begin
      r0[i] = ~serial[0];
      r1[i] = ~serial[1];
      clk_pulse();
    end
  endtask

  initial begin
    logic [7:0] r0, r1;
    int d0, t0, waited;

    // Reset with random pins
    rst     = 1'b1;
    latch   = 1'($urandom_range(0, 1));
    cclk    = 1'($urandom_range(0, 1));
    buttons = 16'($urandom);
    cyc(3);
    check("rst_serial", 32'(serial), 32'(2'b11));
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(rdone), 0);
    check("rst_tmo", 32'(tmo), 0);
    cclk  = ~cclk;
    latch = ~latch;
    cyc(3);
    check("rst_serial_toggle", 32'(serial), 32'(2'b11));
    latch   = 1'b0;
    cclk    = 1'b0;
    buttons = '0;
    cyc(1);
    rst = 1'b0;
    cyc(5);
    check("post_rst_serial", 32'(serial), 32'(2'b11));
    check("post_rst_busy", 32'(busy), 0);

    // Basic read
    buttons = {8'h3C, 8'hA5};
    d0 = done_seen;
    latch_pulse();
    check("basic_busy", 32'(busy), 1);
    read_bits(r0, r1);
    check("basic_pad0", 32'(r0), 32'h A5);
    check("basic_pad1", 32'(r1), 32'h 3C);
    check("basic_done_count", done_seen - d0, 1);
    check("basic_done_serial", 32'(serial_at_done), 32'(2'b00));

    // Overrun
    d0 = done_seen;
    clk_pulse();
    check("overrun1_serial", 32'(serial), 32'(2'b00));
    clk_pulse();
    check("overrun2_serial", 32'(serial), 32'(2'b00));
    check("overrun_done_count", done_seen - d0, 0);
    check("overrun_busy", 32'(busy), 1);

    // Load window
    buttons = {8'h3C, 8'h11};
    latch   = 1'b1;
    cyc(4);
    check("win_track_11", 32'(serial[0]), 1);
    buttons[7:0] = 8'h80;
    cyc(2);
    check("win_track_80", 32'(serial[0]), 0);
    latch = 1'b0;
    cyc(4);
    buttons[7:0] = 8'hFF;
    cyc(2);
    d0 = done_seen;
    read_bits(r0, r1);
    check("win_pad0", 32'(r0), 32'h80);
    check("win_pad1", 32'(r1), 32'h3C);
    check("win_done_count", done_seen - d0, 1);

    // Restart after 3 shifts
    buttons = {8'hC3, 8'h5A};
    d0 = done_seen;
    latch_pulse();
    clk_pulse();
    clk_pulse();
    clk_pulse();
    buttons = {8'h69, 8'h96};
    latch_pulse();
    read_bits(r0, r1);
    check("restart_pad0", 32'(r0), 32'h96);
    check("restart_pad1", 32'(r1), 32'h69);
    check("restart_done_count", done_seen - d0, 1);
    check("restart_done_serial", 32'(serial_at_done), 32'(2'b00));

    // Latch rise coincident with clock rise
    buttons = {8'h0F, 8'hF0};
    cclk  = 1'b1;
    latch = 1'b1;
    cyc(4);
    cclk = 1'b0;
    cyc(4);
    latch = 1'b0;
    cyc(4);
    d0 = done_seen;
    read_bits(r0, r1);
    check("collide_pad0", 32'(r0), 32'hF0);
    check("collide_pad1", 32'(r1), 32'h0F);
    check("collide_done_count", done_seen - d0, 1);

    // Timeout after 2 shifts: shreg0 = 0x97 (pin 0), shreg1 = 0x73 (pin 1)
    buttons = {8'h1C, 8'hA5};
    latch_pulse();
    clk_pulse();
    clk_pulse();
    t0 = tmo_seen;
    d0 = done_seen;
    check("tmo_pre_serial", 32'(serial), 32'(2'b10));
    cyc(T - 60);
    check("tmo_not_early", tmo_seen - t0, 0);
    check("tmo_busy_before", 32'(busy), 1);
    waited = 0;
    while (tmo_seen == t0 && waited < 200) begin
      cyc(1);
      waited++;
    end
    cyc(2);
    check("tmo_pulse_count", tmo_seen - t0, 1);
    check("tmo_busy_after", 32'(busy), 0);
    check("tmo_serial_kept", 32'(serial), 32'(2'b10));
    clk_pulse();
    check("idle_shift_serial", 32'(serial), 32'(2'b01));
    check("idle_busy", 32'(busy), 0);
    check("idle_done_count", done_seen - d0, 0);

    // Asynchronous reset mid-shift: pad0 0x55 after 3 shifts drives pin low
    buttons = {8'hAA, 8'h55};
    latch_pulse();
    clk_pulse();
    clk_pulse();
    clk_pulse();
    check("midrst_pre_busy", 32'(busy), 1);
    check("midrst_pre_serial", 32'(serial[0]), 0);
    rst = 1'b1;
    #1;
    check("midrst_serial", 32'(serial), 32'(2'b11));
    check("midrst_busy", 32'(busy), 0);
    cyc(2);
    rst = 1'b0;
    cyc(3);
    check("midrst_after_busy", 32'(busy), 0);
    check("midrst_after_serial", 32'(serial), 32'(2'b11));
    buttons = {8'hE7, 8'h18};
    latch_pulse();
    read_bits(r0, r1);
    check("recover_pad0", 32'(r0), 32'h18);
    check("recover_pad1", 32'(r1), 32'hE7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded its time budget, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/controller_emulator.md
# controller_emulator

Device-side counterpart of the console's serial game-controller port. It presents `NUM_CONTROLLERS` virtual NES-style pads to an external host that drives latch and controller-clock pins. For each pad it parallel-loads an 8-bit button word while latch is high, then shifts it out MSB-first, active-low, one bit per rising controller-clock edge. Used for loopback verification of the console's controller reader and for bridging soft button sources (debug UART, USB bridge) onto a physical controller port.

## Interface

Parameters:
- `NUM_CONTROLLERS`, 2, number of emulated pads.
- `FILL_BIT`, 1'b1, active-high bit shifted in behind the data; after 8 shifts, `serial_LIST_no` reads `~FILL_BIT`.
- `TIMEOUT_CYCLES`, 4096, `clk` cycles without a controller-clock edge in SHIFT before abandoning the read.

Ports:
- `clk` in 1: system clock; all state on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `latch_i` in 1: host latch pin, asynchronous to `clk`.
- `ctrl_clk_i` in 1: host controller-clock pin, asynchronous; rising edge shifts.
- `buttons_LIST_i` in 8*N: active-high button words; pad k at `[8k+:8]`; bit 7 transmitted first.
- `serial_LIST_no` out N: active-low serial data, one bit per pad.
- `busy_o` out 1: high whenever state ≠ IDLE.
- `read_done_o` out 1: one-cycle pulse on the 8th shift of a read.
- `timeout_o` out 1: one-cycle pulse when SHIFT times out.

## Operation

- `latch_i` and `ctrl_clk_i` pass through 2-flop synchronizers; rise and fall are detected on the synchronized signal against its previous value.
- Per pad: 8-bit `shreg`. `serial_no[k] = ~shreg_k[7]` (registered).
- States: IDLE, LOAD, SHIFT, DONE.
  - Any state, synced latch high: enter or stay in LOAD. Every cycle, load `shreg_k <= buttons_k`, clear `bit_cnt` (4 bits) and the timeout counter. Clock edges are ignored.
  - LOAD, latch fall -> SHIFT. `shreg` holds the value loaded on the last latch-high cycle.
  - SHIFT, clock rise: `shreg <= {shreg[6:0], FILL_BIT}` and `bit_cnt++`. When `bit_cnt` goes 7->8, pulse `read_done_o` and move to DONE.
  - DONE, clock rise: keep shifting `FILL_BIT`. `bit_cnt` saturates at 8 and there is no further `read_done_o`.
  - SHIFT with no clock rise for `TIMEOUT_CYCLES` consecutive cycles: pulse `timeout_o` and move to IDLE. `shreg` is retained. The counter resets on every rise.
  - IDLE/DONE: clock rises shift fill bits; `busy_o` is 0 in IDLE and 1 in DONE.
- Simultaneous latch rise and clock rise in one cycle: the latch wins and no shift occurs.
- `buttons_LIST_i` changes outside LOAD have no effect.
- Reset, asynchronous, including mid-read: state IDLE, `shreg` = 0, `bit_cnt` = 0, synchronizer flops 0. Outputs: `serial_LIST_no` = all 1, `busy_o` = 0, `read_done_o` = 0, `timeout_o` = 0.

## Timing

- Latency from a pin edge to its effect on the outputs is 3 `clk` cycles: 2 synchronizer cycles plus 1 register cycle.
  - Latch rise -> `serial_no` = `~buttons[7]` 3 cycles later; it then tracks `buttons_i` with 1-cycle latency while latch is high.
  - Clock rise -> next bit on `serial_no` 3 cycles later.
- Host requirements:
  - Latch high ≥ 3 `clk` cycles.
  - Controller-clock high and low phases each ≥ 4 `clk` cycles.
  - Host samples data no earlier than 3 `clk` cycles after its clock rise.
- `read_done_o` is asserted in the same cycle the 8th shifted value appears on `serial_no`.
- `timeout_o` fires exactly `TIMEOUT_CYCLES` cycles after the last edge, or after the latch fall if no edge occurred.

## Structure

- `mapache64` package gets `controller_emu_state_t` (enum logic [1:0]: IDLE, LOAD, SHIFT, DONE). Reuse `mapache64::data_t` for `shreg`.
- One state machine and one timeout counter shared across pads. The per-pad `shreg` lives in a generate loop.
- Sub-module `sync_edge_detect`: 2-flop synchronizer plus rise/fall pulses, async reset to 0. Instantiated for `latch_i` and `ctrl_clk_i`.

## Test plan

- Reset: hold `rst` with random pins -> `serial_LIST_no` = 2'b11, `busy_o` = 0. Deassert with pins low -> IDLE, outputs unchanged.
- Basic read: pad0 = 0xA5, pad1 = 0x3C, latch pulse, 8 clock pulses. Host-side inverted samples must be 0xA5 and 0x3C MSB-first, with exactly one `read_done_o` pulse, coincident with the 8th bit.
- Overrun: 2 further clock pulses after a read -> `serial_no` = 0 for each pad, no `read_done_o`, `busy_o` = 1.
- Load window: change pad0 0x11->0x80 while latch is high, then 0x80->0xFF after the latch fall -> 0x80 transmitted.
- Restart and collision: latch asserted after 3 shifts, plus a latch rise coincident with a clock rise -> full reload, no shift that cycle, all 8 bits re-sent from bit 7.
- Timeout and reset: latch, 2 clocks, then idle `TIMEOUT_CYCLES` -> one `timeout_o` pulse, `busy_o` 0. Separately, assert `rst` mid-shift -> immediate all-1 outputs and IDLE.
